// File: rtl/asp_rx_buffer.sv
// ASP network receive stage: tag filter, DEPTH-entry host FIFO, drop flags and a saturating drop counter.
// Optional macro ASP_RX_PARITY_EN adds an even-parity bit (MSB) over the data field of each network word.
module asp_rx_buffer #(
  parameter int DATA_SIZE = 32,
  parameter int TAG_SIZE  = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_SIZE  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TAG_SIZE-1:0]           own_tag_in,
  input  logic                          network_data_ready_in,
`ifdef ASP_RX_PARITY_EN
  input  logic [DATA_SIZE+TAG_SIZE:0]   network_data_tag_in,
`else
  input  logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_in,
`endif
  output logic                          network_ACK_out,
  input  logic                          host_ACK_in,
  output logic                          host_data_ready_out,
  output logic [DATA_SIZE-1:0]          host_data_out,
  output logic                          fifo_full_out,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count_out,
  output logic                          tag_error_out,
  output logic                          overflow_error_out,
  output logic                          parity_error_out,
  output logic [CNT_SIZE-1:0]           drop_count_out
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]       CNT_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
  localparam logic [CNT_SIZE-1:0] DROP_ONE  = CNT_SIZE'(1);

`ifdef ASP_RX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_SIZE-1:0] d);
    even_parity = ^d;
  endfunction
`endif

  logic [DATA_SIZE-1:0] mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r;

  logic [TAG_SIZE-1:0]  tag_s;
  logic [DATA_SIZE-1:0] data_s;
  logic                 match_s, parity_bad_s, pop_s, full_s;
  logic                 push_s, tag_drop_s, par_drop_s, ovf_drop_s, drop_s;
  logic [CW-1:0]        count_next_s;
  logic [AW-1:0]        rd_next_s;
  logic                 empty_after_pop_s;
  logic [DATA_SIZE-1:0] head_next_s, data_next_s;
  logic [CNT_SIZE-1:0]  drop_next_s;

  assign tag_s   = network_data_tag_in[TAG_SIZE-1:0];
  assign data_s  = network_data_tag_in[DATA_SIZE+TAG_SIZE-1:TAG_SIZE];
  assign match_s = (tag_s == own_tag_in) || (tag_s == {TAG_SIZE{1'b1}});
`ifdef ASP_RX_PARITY_EN
  assign parity_bad_s = network_data_tag_in[DATA_SIZE+TAG_SIZE] != even_parity(data_s);
`else
  assign parity_bad_s = 1'b0;
`endif
  assign pop_s  = (count_r != '0) && host_ACK_in;
  assign full_s = (count_r == CNT_DEPTH);

  // Classify the presented word; a pop in the same cycle frees a slot for a full FIFO
  always_comb begin
    push_s     = 1'b0;
    tag_drop_s = 1'b0;
    par_drop_s = 1'b0;
    ovf_drop_s = 1'b0;
    if (network_data_ready_in) begin
      if (!match_s) begin
        tag_drop_s = 1'b1;
      end else if (parity_bad_s) begin
        par_drop_s = 1'b1;
      end else if (full_s && !pop_s) begin
        ovf_drop_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign drop_s = tag_drop_s | par_drop_s | ovf_drop_s;

  // Next occupancy, head pointer and the word that will sit at the head after this edge
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    // When the queue is empty apart from this push, the head is the incoming word itself
    empty_after_pop_s = (count_r == '0) || (pop_s && (count_r == CNT_ONE));
    if (push_s && empty_after_pop_s) begin
      head_next_s = data_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
    if (count_next_s != '0) begin
      data_next_s = head_next_s;
    end else begin
      data_next_s = host_data_out;
    end
    if (drop_s && (drop_count_out != {CNT_SIZE{1'b1}})) begin
      drop_next_s = drop_count_out + DROP_ONE;
    end else begin
      drop_next_s = drop_count_out;
    end
  end

  // Storage array; contents need no reset since pointers and count define validity
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_r[wr_ptr_r] <= data_s;
    end
  end

  // Pointers, occupancy and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r            <= '0;
      rd_ptr_r            <= '0;
      count_r             <= '0;
      network_ACK_out     <= 1'b0;
      host_data_ready_out <= 1'b0;
      host_data_out       <= '0;
      fifo_full_out       <= 1'b0;
      fifo_count_out      <= '0;
      tag_error_out       <= 1'b0;
      overflow_error_out  <= 1'b0;
      parity_error_out    <= 1'b0;
      drop_count_out      <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r            <= rd_next_s;
      count_r             <= count_next_s;
      network_ACK_out     <= push_s;
      host_data_ready_out <= (count_next_s != '0);
      host_data_out       <= data_next_s;
      fifo_full_out       <= (count_next_s == CNT_DEPTH);
      fifo_count_out      <= count_next_s;
      tag_error_out       <= tag_drop_s;
      overflow_error_out  <= ovf_drop_s;
      parity_error_out    <= par_drop_s;
      drop_count_out      <= drop_next_s;
    end
  end

endmodule

// File: tb/tb_asp_rx_buffer.sv
// Randomized bench for asp_rx_buffer against a queue-based reference model (honours ASP_RX_PARITY_EN).
module tb_asp_rx_buffer;
  localparam int DS = 32;
  localparam int TS = 8;
  localparam int DEPTH = 4;
  localparam int CS = 16;
  localparam int CW = $clog2(DEPTH+1);
`ifdef ASP_RX_PARITY_EN
  localparam int WW = DS+TS+1;
`else
  localparam int WW = DS+TS;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [TS-1:0] own_tag_in;
  logic          network_data_ready_in;
  logic [WW-1:0] network_data_tag_in;
  logic          network_ACK_out;
  logic          host_ACK_in;
  logic          host_data_ready_out;
  logic [DS-1:0] host_data_out;
  logic          fifo_full_out;
  logic [CW-1:0] fifo_count_out;
  logic          tag_error_out, overflow_error_out, parity_error_out;
  logic [CS-1:0] drop_count_out;

  asp_rx_buffer #(.DATA_SIZE(DS), .TAG_SIZE(TS), .DEPTH(DEPTH), .CNT_SIZE(CS)) dut (
    .clk(clk), .reset(reset), .own_tag_in(own_tag_in),
    .network_data_ready_in(network_data_ready_in), .network_data_tag_in(network_data_tag_in),
    .network_ACK_out(network_ACK_out), .host_ACK_in(host_ACK_in),
    .host_data_ready_out(host_data_ready_out), .host_data_out(host_data_out),
    .fifo_full_out(fifo_full_out), .fifo_count_out(fifo_count_out),
    .tag_error_out(tag_error_out), .overflow_error_out(overflow_error_out),
    .parity_error_out(parity_error_out), .drop_count_out(drop_count_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [DS-1:0] q[$];
  int unsigned   drops;
  logic [DS-1:0] last_data;
  logic          e_ack, e_tag, e_ovf, e_par;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [DS-1:0] d, input logic [TS-1:0] t, input logic good);
`ifdef ASP_RX_PARITY_EN
    logic p;
    p = good ? ^d : ~(^d);
    mk = {p, d, t};
`else
    mk = {d, t} ^ {WW{1'b0 & good}};
`endif
  endfunction

  task automatic model_step(input logic rst, input logic rdy, input logic [WW-1:0] w, input logic hk);
    logic pop, bad_par;
    logic [TS-1:0] t;
    logic [DS-1:0] d;
    e_ack = 1'b0; e_tag = 1'b0; e_ovf = 1'b0; e_par = 1'b0;
    if (rst) begin
      q.delete();
      drops = 0;
      last_data = '0;
    end else begin
      pop = (q.size() != 0) && hk;
      t = w[TS-1:0];
      d = w[DS+TS-1:TS];
      bad_par = 1'b0;
`ifdef ASP_RX_PARITY_EN
      bad_par = (w[WW-1] != ^d);
`endif
      if (rdy) begin
        if (t != own_tag_in && t != 8'hFF) e_tag = 1'b1;
        else if (bad_par) e_par = 1'b1;
        else if (q.size() == DEPTH && !pop) e_ovf = 1'b1;
        else e_ack = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (e_ack) q.push_back(d);
      if ((e_tag || e_par || e_ovf) && drops < 32'd65535) drops++;
      if (q.size() != 0) last_data = q[0];
    end
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic [WW-1:0] w, input logic hk);
    reset = rst;
    network_data_ready_in = rdy;
    network_data_tag_in = w;
    host_ACK_in = hk;
    @(posedge clk);
    #1;
    model_step(rst, rdy, w, hk);
    check_eq("ack",      64'(network_ACK_out),     64'(e_ack));
    check_eq("tag_err",  64'(tag_error_out),       64'(e_tag));
    check_eq("ovf_err",  64'(overflow_error_out),  64'(e_ovf));
    check_eq("par_err",  64'(parity_error_out),    64'(e_par));
    check_eq("ready",    64'(host_data_ready_out), 64'(q.size() != 0));
    check_eq("data",     64'(host_data_out),       64'(last_data));
    check_eq("full",     64'(fifo_full_out),       64'(q.size() == DEPTH));
    check_eq("count",    64'(fifo_count_out),      64'(q.size()));
    check_eq("drops",    64'(drop_count_out),      64'(drops));
  endtask

  initial begin
    logic [TS-1:0] t;
    int r;
    reset = 1'b1; own_tag_in = 8'hAB; network_data_ready_in = 1'b0;
    network_data_tag_in = '0; host_ACK_in = 1'b0;

    cycle(1'b1, 1'b0, '0, 1'b0);
    check_eq("rst_data", 64'(host_data_out), 64'h0);

    // tag match
    cycle(1'b0, 1'b1, mk(32'h0000_1234, 8'hAB, 1'b1), 1'b0);
    check_eq("tp1_ack",   64'(network_ACK_out), 64'h1);
    check_eq("tp1_data",  64'(host_data_out),   64'h1234);
    check_eq("tp1_count", 64'(fifo_count_out),  64'h1);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // tag mismatch, then broadcast
    cycle(1'b0, 1'b1, mk(32'h0000_1234, 8'hAC, 1'b1), 1'b0);
    check_eq("tp2_drops", 64'(drop_count_out), 64'h1);
    cycle(1'b0, 1'b1, mk(32'h0000_5678, 8'hFF, 1'b1), 1'b0);
    check_eq("tp2_bcast", 64'(network_ACK_out), 64'h1);

    // overflow
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, mk(32'(i + 1), 8'hAB, 1'b1), 1'b0);
    check_eq("tp3_ovf", 64'(overflow_error_out), 64'h1);
    cycle(1'b0, 1'b1, mk(32'h0000_0006, 8'hAB, 1'b1), 1'b1);
    check_eq("tp3_full_pushpop", 64'(fifo_count_out), 64'h4);

    // drain order and pointer wrap
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, mk(32'h11, 8'hAB, 1'b1), 1'b0);
    cycle(1'b0, 1'b1, mk(32'h22, 8'hAB, 1'b1), 1'b0);
    cycle(1'b0, 1'b1, mk(32'h33, 8'hAB, 1'b1), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    check_eq("tp4_empty", 64'(host_data_ready_out), 64'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, mk(32'(8'h40 + i), 8'hAB, 1'b1), 1'b1);

    // reset mid-operation
    cycle(1'b0, 1'b1, mk(32'h51, 8'hAB, 1'b1), 1'b0);
    cycle(1'b0, 1'b1, mk(32'h52, 8'hAB, 1'b1), 1'b0);
    cycle(1'b1, 1'b1, mk(32'h53, 8'hAB, 1'b1), 1'b0);
    check_eq("tp5_count", 64'(fifo_count_out), 64'h0);

`ifdef ASP_RX_PARITY_EN
    cycle(1'b0, 1'b1, {1'b0, 32'h1, 8'hAB}, 1'b0);
    check_eq("tp6_par_drop", 64'(parity_error_out), 64'h1);
    cycle(1'b0, 1'b1, {1'b1, 32'h1, 8'hAB}, 1'b0);
    check_eq("tp6_par_ok", 64'(network_ACK_out), 64'h1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) own_tag_in = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 50) t = own_tag_in;
      else if (r < 65) t = 8'hFF;
      else t = 8'($urandom);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70),
            mk($urandom, t, ($urandom_range(0, 9) != 0)), ($urandom_range(0, 99) < 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
